// File: rtl/reset_sequencer.sv
// reset_sequencer: turns the raw asynchronous board Reset into staged controls
// for the datapath. Reset asserts immediately and is released through a 2-flop
// synchroniser. After release, PC_Reset is held for HOLD_CYCLES edges. Pipe_Flush
// then stays high for a further FLUSH_CYCLES edges, and after that Run asserts.
// Ext_Reset_Req restarts the HOLD/FLUSH sequence without a full reset.
// Optional feature macro: RST_SEQ_RUN_COUNT_EN. When it is defined, Run_Cycles
// counts RUN cycles and saturates. When it is not defined, Run_Cycles is tied to 0.
module reset_sequencer #(
  parameter int HOLD_CYCLES  = 5,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ext_Reset_Req,
  output logic             PC_Reset,
  output logic             Pipe_Flush,
  output logic             Run,
  output logic [CNT_W-1:0] Run_Cycles
);

  // The phase counter only has to hold the larger load value (minimum width 1).
  localparam int MAX_HF   = (HOLD_CYCLES > FLUSH_CYCLES) ? HOLD_CYCLES : FLUSH_CYCLES;
  localparam int MAX_CNT  = (MAX_HF > 2) ? MAX_HF : 2;
  localparam int CNT_BITS = $clog2(MAX_CNT);

  localparam logic [CNT_BITS-1:0] HOLD_LOAD  = CNT_BITS'(HOLD_CYCLES - 1);
  // When FLUSH_CYCLES is 0, FLUSH is skipped, so this load value is never used.
  localparam logic [CNT_BITS-1:0] FLUSH_LOAD =
      (FLUSH_CYCLES > 0) ? CNT_BITS'(FLUSH_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          sync_reg, sync_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;

  // Next-state logic. The registered outputs below decode state_next, so the
  // outputs change on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    sync_next  = sync_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      SYNC: begin
        sync_next = {sync_reg[0], 1'b1};
        if (sync_reg[0]) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (Ext_Reset_Req) begin
          cnt_next = HOLD_LOAD;
        end else if (cnt_reg == '0) begin
          if (FLUSH_CYCLES == 0) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      FLUSH: begin
        if (Ext_Reset_Req) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else if (cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RUN: begin
        if (Ext_Reset_Req) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      default: begin
        state_next = SYNC;
        sync_next  = 2'b00;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM state and the registered control outputs. Reset asserts asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= SYNC;
      sync_reg   <= 2'b00;
      cnt_reg    <= '0;
      PC_Reset   <= 1'b1;
      Pipe_Flush <= 1'b1;
      Run        <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sync_reg   <= sync_next;
      cnt_reg    <= cnt_next;
      PC_Reset   <= (state_next == SYNC) || (state_next == HOLD);
      Pipe_Flush <= (state_next != RUN);
      Run        <= (state_next == RUN);
    end
  end

`ifdef RST_SEQ_RUN_COUNT_EN
  logic [CNT_W-1:0] run_cycles_reg;

  // Counts the edges seen in RUN and saturates at all-ones. A restart request clears it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_cycles_reg <= '0;
    end else if (Ext_Reset_Req) begin
      run_cycles_reg <= '0;
    end else if ((state_reg == RUN) && (run_cycles_reg != '1)) begin
      run_cycles_reg <= run_cycles_reg + 1'b1;
    end
  end

  assign Run_Cycles = run_cycles_reg;
`else
  assign Run_Cycles = '0;
`endif

endmodule
